// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the program loader / instruction responder.
package instr_loader_pkg;
   typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
   localparam logic [7:0] HALT_INSTR = 8'hC3;
   localparam int         PROG_DEPTH = 256;
endpackage

// File: rtl/prog_ram.sv
// Program RAM: one synchronous write port, one asynchronous read port, no reset.
module prog_ram #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              CLK,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);
   logic [DATA_W-1:0] r_mem [2**ADDR_W];

   always_ff @(posedge CLK) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/instr_loader.sv
// Loads a program over a valid/ready port into RAM, then serves CPU fetches;
// fetches beyond the loaded program return a self-loop halt instruction.
module instr_loader import instr_loader_pkg::*; #(
   parameter int         ADDR_W     = 8,
   parameter logic [7:0] HALT_INSTR = instr_loader_pkg::HALT_INSTR
) (
   input  logic            CLK,
   input  logic            Reset,
   input  logic [ADDR_W-1:0] pc,
   output logic [7:0]      instruction,
   input  logic            load_start,
   input  logic            load_valid,
   input  logic [7:0]      load_data,
   input  logic            load_last,
   output logic            load_ready,
   output logic            running,
   output logic            halted,
   output logic [ADDR_W:0] prog_len
);
   localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'((2**ADDR_W) - 1);

   state_t            r_state;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [ADDR_W:0]   r_prog_len;
   logic              w_we;
   logic              w_full;
   logic              w_in_prog;
   logic [7:0]        w_rdata;

   // load_start beats a coincident byte, so it is never written
   assign w_we      = (r_state == LOAD) && load_valid && !load_start;
   assign w_full    = (r_prog_len == LAST_CNT);
   assign w_in_prog = ({1'b0, pc} < r_prog_len);

   always_ff @(posedge CLK) begin
      if (Reset) begin
         r_state    <= IDLE;
         r_wr_addr  <= '0;
         r_prog_len <= '0;
      end else begin
         case (r_state)
            IDLE, RUN: begin
               if (load_start) begin
                  r_state    <= LOAD;
                  r_wr_addr  <= '0;
                  r_prog_len <= '0;
               end
            end
            LOAD: begin
               if (load_start) begin
                  r_wr_addr  <= '0;
                  r_prog_len <= '0;
               end else if (load_valid) begin
                  // the final slot is filled without bumping the address past the end
                  if (!w_full) r_wr_addr <= r_wr_addr + 1'b1;
                  r_prog_len <= r_prog_len + 1'b1;
                  if (load_last || w_full) r_state <= RUN;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   prog_ram #(.ADDR_W(ADDR_W), .DATA_W(8)) u_ram (
      .CLK     (CLK),
      .i_we    (w_we),
      .i_waddr (r_wr_addr),
      .i_wdata (load_data),
      .i_raddr (pc),
      .o_rdata (w_rdata)
   );

   assign load_ready  = (r_state == LOAD);
   assign running     = (r_state == RUN);
   assign halted      = running && !w_in_prog;
   assign prog_len    = r_prog_len;
   assign instruction = (running && w_in_prog) ? w_rdata : HALT_INSTR;
endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader with a scoreboard of loaded bytes.
module tb_instr_loader;
   logic       CLK = 1'b0;
   logic       Reset;
   logic [7:0] pc;
   logic [7:0] instruction;
   logic       load_start, load_valid, load_last;
   logic [7:0] load_data;
   logic       load_ready, running, halted;
   logic [8:0] prog_len;

   int errors = 0;
   int checks = 0;
   logic [7:0] sb [$];

   instr_loader dut (
      .CLK         (CLK),
      .Reset       (Reset),
      .pc          (pc),
      .instruction (instruction),
      .load_start  (load_start),
      .load_valid  (load_valid),
      .load_data   (load_data),
      .load_last   (load_last),
      .load_ready  (load_ready),
      .running     (running),
      .halted      (halted),
      .prog_len    (prog_len)
   );

   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic pulse_start();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] d, input logic last);
      load_valid = 1'b1;
      load_data  = d;
      load_last  = last;
      sb.push_back(d);
      tick();
      load_valid = 1'b0;
      load_last  = 1'b0;
   endtask

   // Pops expected bytes in address order and compares each fetch.
   task automatic check_prog(input int n);
      for (int i = 0; i < n; i++) begin
         pc = 8'(i);
         #1;
         if (sb.size() == 0) begin
            chk("sb_empty", 16'(i), 16'hFFFF);
         end else begin
            chk($sformatf("fetch[%0d]", i), {8'h0, instruction}, {8'h0, sb.pop_front()});
            chk($sformatf("halted[%0d]", i), {15'h0, halted}, 16'h0);
         end
      end
   endtask

   initial begin
      Reset = 1'b1; pc = '0; load_start = 0; load_valid = 0; load_last = 0; load_data = '0;
      tick(); tick();
      Reset = 1'b0;
      tick();

      // reset state
      pc = 8'h00; #1 chk("rst_pc00", {8'h0, instruction}, 16'hC3);
      pc = 8'h7F; #1 chk("rst_pc7F", {8'h0, instruction}, 16'hC3);
      pc = 8'hFF; #1 chk("rst_pcFF", {8'h0, instruction}, 16'hC3);
      chk("rst_ready", {15'h0, load_ready}, 16'h0);
      chk("rst_running", {15'h0, running}, 16'h0);
      chk("rst_halted", {15'h0, halted}, 16'h0);
      chk("rst_len", {7'h0, prog_len}, 16'h0);

      // 3-byte program with load_last
      pulse_start();
      chk("load_ready", {15'h0, load_ready}, 16'h1);
      pc = 8'h00; #1 chk("load_fetch", {8'h0, instruction}, 16'hC3);
      send_byte(8'h11, 0);
      send_byte(8'h62, 0);
      chk("pre_last_run", {15'h0, running}, 16'h0);
      send_byte(8'hC3, 1);
      chk("p3_running", {15'h0, running}, 16'h1);
      chk("p3_len", {7'h0, prog_len}, 16'd3);
      chk("p3_ready", {15'h0, load_ready}, 16'h0);
      pc = 8'd1; #1 chk("p3_pc1", {8'h0, instruction}, 16'h62);
      check_prog(3);
      pc = 8'd3; #1 chk("p3_pc3", {8'h0, instruction}, 16'hC3);
      chk("p3_halted", {15'h0, halted}, 16'h1);

      // gapped valid; a bare load_last in a gap must be ignored
      pulse_start();
      for (int i = 0; i < 4; i++) begin
         send_byte(8'h30 + 8'(i), (i == 3));
         if (i < 3) begin
            load_data = 8'hEE; load_last = (i == 0); tick();
            load_last = 1'b0; tick();
         end
      end
      chk("gap_running", {15'h0, running}, 16'h1);
      chk("gap_len", {7'h0, prog_len}, 16'd4);
      check_prog(4);

      // 256 back-to-back bytes, no load_last
      pulse_start();
      for (int i = 0; i < 255; i++) send_byte(8'(i), 0);
      chk("full255_running", {15'h0, running}, 16'h0);
      chk("full255_len", {7'h0, prog_len}, 16'd255);
      send_byte(8'hFF, 0);
      chk("full_running", {15'h0, running}, 16'h1);
      chk("full_len", {7'h0, prog_len}, 16'd256);
      check_prog(256);
      pc = 8'hFF; #1 chk("full_pcFF", {8'h0, instruction}, 16'hFF);
      chk("full_halted", {15'h0, halted}, 16'h0);

      // restart with a coincident byte: the byte is dropped
      pulse_start();
      send_byte(8'hA1, 0);
      send_byte(8'hA2, 0);
      sb.delete();
      load_start = 1'b1; load_valid = 1'b1; load_data = 8'hEE;
      tick();
      load_start = 1'b0; load_valid = 1'b0;
      chk("rs_len", {7'h0, prog_len}, 16'h0);
      chk("rs_ready", {15'h0, load_ready}, 16'h1);
      send_byte(8'h5A, 0);
      send_byte(8'h5B, 1);
      chk("rs_len2", {7'h0, prog_len}, 16'd2);
      check_prog(2);

      // load_start while running
      pulse_start();
      chk("rr_running", {15'h0, running}, 16'h0);
      pc = 8'd0; #1 chk("rr_pc0", {8'h0, instruction}, 16'hC3);
      pc = 8'd1; #1 chk("rr_pc1", {8'h0, instruction}, 16'hC3);
      send_byte(8'h9D, 0);
      pc = 8'd0; #1 chk("rr_mid", {8'h0, instruction}, 16'hC3);
      send_byte(8'h4E, 1);
      chk("rr_running2", {15'h0, running}, 16'h1);
      check_prog(2);

      // reset in the middle of a load
      pulse_start();
      send_byte(8'h01, 0);
      send_byte(8'h02, 0);
      sb.delete();
      Reset = 1'b1; tick(); Reset = 1'b0;
      chk("rl_ready", {15'h0, load_ready}, 16'h0);
      chk("rl_running", {15'h0, running}, 16'h0);
      chk("rl_len", {7'h0, prog_len}, 16'h0);
      pc = 8'd0; #1 chk("rl_pc0", {8'h0, instruction}, 16'hC3);

      // reset beats load_start
      Reset = 1'b1; load_start = 1'b1; tick();
      Reset = 1'b0; load_start = 1'b0;
      chk("rp_ready", {15'h0, load_ready}, 16'h0);
      tick();
      chk("rp_ready2", {15'h0, load_ready}, 16'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
